// File: rtl/rmii_pkg.sv
// Shared RMII receive/transmit definitions: FSM encodings, CRC-32 constants,
// the end-of-frame status record and the 2-bit reflected CRC step.
package rmii_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t PRE  = 2'd1;
  localparam state_t DATA = 2'd2;
  localparam state_t DROP = 2'd3;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef struct packed {
    logic        good;
    logic        crc;
    logic        len;
    logic        align;
    logic        rxer;
    logic [15:0] bytes;
  } rx_stat_t;

  // Bit 0 of the dibit is first on the wire, so it is folded in first.
  function automatic logic [31:0] crc32_step2(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ dibit[i]) c = (c >> 1) ^ CRC_POLY;
      else                 c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, assembles LSB-first bytes,
// checks CRC-32 residue and length, and reports one status pulse per frame.
module rmii_rx_deframer
  import rmii_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  rxd_i,
  input  logic        crs_dv_i,
  input  logic        rx_er_i,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  output logic        m_last_o,
  output logic        stat_valid_o,
  output logic        stat_good_o,
  output logic        stat_crc_o,
  output logic        stat_len_o,
  output logic        stat_align_o,
  output logic        stat_rxer_o,
  output logic [15:0] stat_bytes_o
);

  localparam logic [15:0] MIN_LEN = MIN_FRAME[15:0];
  localparam logic [15:0] MAX_LEN = MAX_FRAME[15:0];
  localparam logic [15:0] SAT_LEN = MAX_LEN + 16'd1;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  dibit_cnt_q, dibit_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_byte_q, crc_byte_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        rxer_q, rxer_d;
  logic [7:0]  held_q, held_d;
  logic        held_valid_q, held_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        stat_valid_q, stat_valid_d;
  rx_stat_t    stat_q, stat_d;

  logic [7:0]  new_byte;
  logic [31:0] crc_next;
  logic        crc_bad;
  logic        len_bad;

  assign new_byte = {rxd_i, shift_q[7:2]};
  assign crc_next = crc32_step2(crc_q, rxd_i);
  // The CRC snapshot at the last byte boundary ignores any trailing partial byte.
  assign crc_bad  = (crc_byte_q != CRC_RESIDUE);
  assign len_bad  = (byte_cnt_q < MIN_LEN) || (byte_cnt_q > MAX_LEN);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    dibit_cnt_d  = dibit_cnt_q;
    crc_d        = crc_q;
    crc_byte_d   = crc_byte_q;
    byte_cnt_d   = byte_cnt_q;
    rxer_d       = rxer_q;
    held_d       = held_q;
    held_valid_d = held_valid_q;
    m_data_d     = m_data_q;
    m_valid_d    = 1'b0;
    m_last_d     = 1'b0;
    stat_valid_d = 1'b0;
    stat_d       = stat_q;

    case (state_q)
      IDLE: begin
        if (crs_dv_i) state_d = (rxd_i == PREAMBLE_DIBIT) ? PRE : DROP;
      end
      PRE: begin
        if (!crs_dv_i) begin
          state_d = IDLE;
        end else if (rxd_i == SFD_DIBIT) begin
          state_d      = DATA;
          dibit_cnt_d  = 2'd0;
          crc_d        = CRC_INIT;
          crc_byte_d   = CRC_INIT;
          byte_cnt_d   = 16'd0;
          rxer_d       = 1'b0;
          held_valid_d = 1'b0;
        end else if (rxd_i != PREAMBLE_DIBIT) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (crs_dv_i) begin
          shift_d     = new_byte;
          crc_d       = crc_next;
          dibit_cnt_d = dibit_cnt_q + 2'd1;
          if (rx_er_i) rxer_d = 1'b1;
          if (dibit_cnt_q == 2'd3) begin
            crc_byte_d = crc_next;
            if (byte_cnt_q != SAT_LEN) byte_cnt_d = byte_cnt_q + 16'd1;
            // One byte is always held back so the frame's final byte can carry m_last.
            if (byte_cnt_d <= MAX_LEN) begin
              m_valid_d    = held_valid_q;
              if (held_valid_q) m_data_d = held_q;
              held_d       = new_byte;
              held_valid_d = 1'b1;
            end
          end
        end else begin
          state_d      = IDLE;
          m_valid_d    = held_valid_q;
          m_last_d     = held_valid_q;
          if (held_valid_q) m_data_d = held_q;
          held_valid_d = 1'b0;
          stat_valid_d = 1'b1;
          stat_d.crc   = crc_bad;
          stat_d.len   = len_bad;
          stat_d.align = (dibit_cnt_q != 2'd0);
          stat_d.rxer  = rxer_q;
          stat_d.good  = !(crc_bad || len_bad || (dibit_cnt_q != 2'd0) || rxer_q);
          stat_d.bytes = byte_cnt_q;
        end
      end
      DROP: begin
        if (!crs_dv_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      shift_q      <= 8'd0;
      dibit_cnt_q  <= 2'd0;
      crc_q        <= CRC_INIT;
      crc_byte_q   <= CRC_INIT;
      byte_cnt_q   <= 16'd0;
      rxer_q       <= 1'b0;
      held_q       <= 8'd0;
      held_valid_q <= 1'b0;
      m_data_q     <= 8'd0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_q       <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      dibit_cnt_q  <= dibit_cnt_d;
      crc_q        <= crc_d;
      crc_byte_q   <= crc_byte_d;
      byte_cnt_q   <= byte_cnt_d;
      rxer_q       <= rxer_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      stat_valid_q <= stat_valid_d;
      stat_q       <= stat_d;
    end
  end

  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign m_last_o     = m_last_q;
  assign stat_valid_o = stat_valid_q;
  assign stat_good_o  = stat_q.good;
  assign stat_crc_o   = stat_q.crc;
  assign stat_len_o   = stat_q.len;
  assign stat_align_o = stat_q.align;
  assign stat_rxer_o  = stat_q.rxer;
  assign stat_bytes_o = stat_q.bytes;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer: drives dibit-level frames and checks the
// byte stream and end-of-frame status against hand-derived expectations.
module tb_rmii_rx_deframer;

  typedef logic [7:0] byteQ_t[$];

  logic        clk;
  logic        rstN;
  logic [1:0]  rxd;
  logic        crsDv;
  logic        rxEr;
  logic [7:0]  mData;
  logic        mValid;
  logic        mLast;
  logic        statValid;
  logic        statGood;
  logic        statCrc;
  logic        statLen;
  logic        statAlign;
  logic        statRxer;
  logic [15:0] statBytes;

  int checkCount = 0;
  int errorCount = 0;

  // Monitor results, cleared before each scenario
  logic [7:0]  rxBytes[$];
  int          lastPos;
  int          lastCount;
  int          statCount;
  logic        capGood, capCrc, capLen, capAlign, capRxer;
  logic [15:0] capBytes;

  rmii_rx_deframer dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .rxd_i        (rxd),
    .crs_dv_i     (crsDv),
    .rx_er_i      (rxEr),
    .m_data_o     (mData),
    .m_valid_o    (mValid),
    .m_last_o     (mLast),
    .stat_valid_o (statValid),
    .stat_good_o  (statGood),
    .stat_crc_o   (statCrc),
    .stat_len_o   (statLen),
    .stat_align_o (statAlign),
    .stat_rxer_o  (statRxer),
    .stat_bytes_o (statBytes)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Outputs change on posedge; record them half a cycle later
  always @(negedge clk) begin
    if (rstN) begin
      if (mValid) begin
        rxBytes.push_back(mData);
        if (mLast) begin
          lastPos = rxBytes.size();
          lastCount++;
        end
      end
      if (statValid) begin
        statCount++;
        capGood  = statGood;
        capCrc   = statCrc;
        capLen   = statLen;
        capAlign = statAlign;
        capRxer  = statRxer;
        capBytes = statBytes;
      end
    end
  end

  function automatic logic [31:0] refFcs(input byteQ_t data);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (data[i]) begin
      c = c ^ {24'd0, data[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byteQ_t buildFrame(input int payloadLen, input logic [7:0] fill);
    byteQ_t f;
    logic [31:0] fcs;
    for (int i = 0; i < payloadLen; i++) f.push_back(fill);
    fcs = refFcs(f);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    return f;
  endfunction

  task automatic applyStimulus(input logic [1:0] d, input logic dv, input logic er);
    @(negedge clk);
    rxd   = d;
    crsDv = dv;
    rxEr  = er;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
      else begin
        errorCount++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic clearMonitor();
    rxBytes.delete();
    lastPos   = 0;
    lastCount = 0;
    statCount = 0;
  endtask

  task automatic sendPreamble();
    for (int i = 0; i < 7; i++) applyStimulus(2'b01, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0);
  endtask

  // Drops the final dropDibits dibits; asserts rx_er across byte erByte (-1 = none)
  task automatic sendBody(input byteQ_t f, input int dropDibits, input int erByte);
    logic [7:0] b;
    for (int i = 0; i < f.size() * 4 - dropDibits; i++) begin
      b = f[i / 4] >> (2 * (i % 4));
      applyStimulus(b[1:0], 1'b1, (i / 4) == erByte);
    end
  endtask

  task automatic endFrame(input int idleCycles);
    applyStimulus(2'b00, 1'b0, 1'b0);
    for (int i = 0; i < idleCycles; i++) applyStimulus(2'b00, 1'b0, 1'b0);
  endtask

  function automatic int streamMismatches(input byteQ_t f, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (i >= rxBytes.size() || rxBytes[i] !== f[i]) bad++;
    return bad;
  endfunction

  byteQ_t frame;
  byteQ_t bad;
  logic [7:0] b;

  initial begin
    rstN  = 1'b0;
    rxd   = 2'b00;
    crsDv = 1'b0;
    rxEr  = 1'b0;
    clearMonitor();
    repeat (3) @(negedge clk);
    checkOutput("reset_m_valid", {31'd0, mValid}, 32'd0);
    checkOutput("reset_stat_valid", {31'd0, statValid}, 32'd0);
    checkOutput("reset_stat_bytes", {16'd0, statBytes}, 32'd0);
    checkOutput("reset_m_data", {24'd0, mData}, 32'd0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] good 64-byte frame");
    frame = buildFrame(60, 8'hA5);
    clearMonitor();
    sendPreamble();
    sendBody(frame, 0, -1);
    endFrame(3);
    checkOutput("t1_count", rxBytes.size(), 64);
    checkOutput("t1_last_pos", lastPos, 64);
    checkOutput("t1_last_count", lastCount, 1);
    checkOutput("t1_stat_count", statCount, 1);
    checkOutput("t1_good", {31'd0, capGood}, 32'd1);
    checkOutput("t1_crc", {31'd0, capCrc}, 32'd0);
    checkOutput("t1_bytes", {16'd0, capBytes}, 32'd64);
    checkOutput("t1_data", streamMismatches(frame, 64), 0);

    $display("[TB] corrupted payload dibit");
    bad = frame;
    bad[10] = bad[10] ^ 8'h03;
    clearMonitor();
    sendPreamble();
    sendBody(bad, 0, -1);
    endFrame(3);
    checkOutput("t2_count", rxBytes.size(), 64);
    checkOutput("t2_crc", {31'd0, capCrc}, 32'd1);
    checkOutput("t2_good", {31'd0, capGood}, 32'd0);
    checkOutput("t2_byte10", (rxBytes.size() > 10) ? {24'd0, rxBytes[10]} : 32'hFFFF, 32'hA6);

    $display("[TB] short check-value frame");
    frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
    clearMonitor();
    sendPreamble();
    sendBody(frame, 0, -1);
    endFrame(3);
    checkOutput("t3_crc", {31'd0, capCrc}, 32'd0);
    checkOutput("t3_len", {31'd0, capLen}, 32'd1);
    checkOutput("t3_good", {31'd0, capGood}, 32'd0);
    checkOutput("t3_bytes", {16'd0, capBytes}, 32'd13);
    checkOutput("t3_count", rxBytes.size(), 13);
    checkOutput("t3_data", streamMismatches(frame, 13), 0);

    $display("[TB] truncated by one dibit");
    frame = buildFrame(60, 8'hA5);
    clearMonitor();
    sendPreamble();
    sendBody(frame, 1, -1);
    endFrame(3);
    checkOutput("t4_align", {31'd0, capAlign}, 32'd1);
    checkOutput("t4_bytes", {16'd0, capBytes}, 32'd63);
    checkOutput("t4_count", rxBytes.size(), 63);
    checkOutput("t4_good", {31'd0, capGood}, 32'd0);

    $display("[TB] oversize frame");
    frame = buildFrame(1596, 8'h5A);
    clearMonitor();
    sendPreamble();
    sendBody(frame, 0, -1);
    endFrame(3);
    checkOutput("t5_count", rxBytes.size(), 1522);
    checkOutput("t5_last_pos", lastPos, 1522);
    checkOutput("t5_len", {31'd0, capLen}, 32'd1);
    checkOutput("t5_bytes", {16'd0, capBytes}, 32'd1523);

    $display("[TB] rx_er inside a good frame");
    frame = buildFrame(60, 8'hA5);
    clearMonitor();
    sendPreamble();
    sendBody(frame, 0, 10);
    endFrame(3);
    checkOutput("t5b_rxer", {31'd0, capRxer}, 32'd1);
    checkOutput("t5b_crc", {31'd0, capCrc}, 32'd0);
    checkOutput("t5b_good", {31'd0, capGood}, 32'd0);

    $display("[TB] reset mid-frame then back-to-back frame");
    clearMonitor();
    sendPreamble();
    for (int i = 0; i < frame.size() * 4; i++) begin
      b = frame[i / 4] >> (2 * (i % 4));
      applyStimulus(b[1:0], 1'b1, 1'b0);
      if (i == 80) rstN = 1'b0;
      if (i == 82) begin
        #1;
        checkOutput("t6_reset_m_valid", {31'd0, mValid}, 32'd0);
        checkOutput("t6_reset_stat_valid", {31'd0, statValid}, 32'd0);
      end
      if (i == 83) begin
        rstN = 1'b1;
        clearMonitor();
      end
    end
    endFrame(0);
    checkOutput("t6_dropped_count", rxBytes.size(), 0);
    sendPreamble();
    sendBody(frame, 0, -1);
    endFrame(3);
    checkOutput("t6_stat_count", statCount, 1);
    checkOutput("t6_count", rxBytes.size(), 64);
    checkOutput("t6_good", {31'd0, capGood}, 32'd1);
    checkOutput("t6_bytes", {16'd0, capBytes}, 32'd64);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
